// File: rtl/pio_cmd_sequencer.sv
// Buffers HPS instruction words from PIO strobes in a small FIFO.
// Issues them one at a time to the execution unit and publishes a status word.
module pio_cmd_sequencer #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] cmd_data,
   input  logic              cmd_wr,
   input  logic              clr_flags,
   output logic [DATA_W-1:0] exec_data,
   output logic              exec_valid,
   input  logic              exec_ready,
   input  logic              exec_done,
   output logic [31:0]       status
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned TW = $clog2(TIMEOUT_CYC);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_e;

   state_e            state_q;
   logic              cmd_wr_q, clr_q;
   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              ovf_q, ovf_d;
   logic              tmo_q;
   logic [TW-1:0]     timer_q;
   logic [7:0]        done_cnt_q;
   logic [DATA_W-1:0] exec_data_q;
   logic              exec_valid_q;
   logic [31:0]       status_q, status_d;

   logic push_c, clr_c, full_c, empty_c, pop_c, wr_en_c, busy_c;

   // Edge detect, FIFO bookkeeping and status word assembly
   always_comb begin
      push_c   = cmd_wr & ~cmd_wr_q;
      clr_c    = clr_flags & ~clr_q;
      full_c   = (count_q == CW'(FIFO_DEPTH));
      empty_c  = (count_q == '0);
      pop_c    = (state_q == S_IDLE) & ~empty_c;
      wr_en_c  = push_c & ~full_c;
      busy_c   = (state_q != S_IDLE) | ~empty_c;
      wr_ptr_d = wr_ptr_q + PW'(wr_en_c);
      rd_ptr_d = rd_ptr_q + PW'(pop_c);
      count_d  = count_q + CW'(wr_en_c) - CW'(pop_c);
      // a push into a full FIFO is dropped even if a pop frees a slot this cycle
      ovf_d    = (push_c & full_c) | (ovf_q & ~clr_c);
      status_d = {8'(state_q), done_cnt_q, 6'd0, 5'(count_q),
                  tmo_q, ovf_q, empty_c, full_c, busy_c};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cmd_wr_q <= 1'b0;
         clr_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         status_q <= 32'h0000_0004;
         for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      end else begin
         cmd_wr_q <= cmd_wr;
         clr_q    <= clr_flags;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         status_q <= status_d;
         if (wr_en_c) mem_q[wr_ptr_q] <= cmd_data;
      end
   end

   // Issue / handshake / completion sequencer
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         exec_data_q  <= '0;
         exec_valid_q <= 1'b0;
         timer_q      <= '0;
         done_cnt_q   <= '0;
         tmo_q        <= 1'b0;
      end else begin
         if (clr_c) tmo_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (pop_c) begin
                  exec_data_q  <= mem_q[rd_ptr_q];
                  exec_valid_q <= 1'b1;
                  state_q      <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (exec_ready) begin
                  exec_valid_q <= 1'b0;
                  timer_q      <= '0;
                  state_q      <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (exec_done) begin
                  done_cnt_q <= done_cnt_q + 8'd1;
                  state_q    <= S_IDLE;
               end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
                  tmo_q   <= 1'b1;
                  state_q <= S_IDLE;
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign exec_data  = exec_data_q;
   assign exec_valid = exec_valid_q;
   assign status     = status_q;

endmodule

// File: tb/tb_pio_cmd_sequencer.sv
// Directed bench for pio_cmd_sequencer: issue, backpressure, overflow,
// timeout, flag clear and mid-operation reset.
module tb_pio_cmd_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] cmd_data;
   logic        cmd_wr, clr_flags, exec_ready, exec_done;
   logic [31:0] exec_data;
   logic        exec_valid;
   logic [31:0] status;

   int n_cmp = 0;
   int n_err = 0;

   pio_cmd_sequencer #(
      .DATA_W(32), .FIFO_DEPTH(4), .TIMEOUT_CYC(16)
   ) dut (
      .clk(clk), .reset(reset), .cmd_data(cmd_data), .cmd_wr(cmd_wr),
      .clr_flags(clr_flags), .exec_data(exec_data), .exec_valid(exec_valid),
      .exec_ready(exec_ready), .exec_done(exec_done), .status(status)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [31:0] w);
      cmd_data = w;
      cmd_wr   = 1'b1;
      tick();
      cmd_wr   = 1'b0;
      tick();
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (!exec_valid && n < 20) begin
         tick();
         n++;
      end
      check_eq(tag, 32'(exec_valid), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; cmd_data = '0; cmd_wr = 1'b0; clr_flags = 1'b0;
      exec_ready = 1'b0; exec_done = 1'b0;
      tick(); tick();
      check_eq("rst_status", status, 32'h0000_0004);
      check_eq("rst_valid", 32'(exec_valid), 32'd0);
      check_eq("rst_data", exec_data, 32'd0);
      reset = 1'b0;
      tick();

      // single command, ready already high
      exec_ready = 1'b1;
      cmd_data = 32'hA5A5_0001; cmd_wr = 1'b1;
      tick();
      check_eq("t1_not_yet", 32'(exec_valid), 32'd0);
      cmd_wr = 1'b0;
      tick();
      check_eq("t1_valid", 32'(exec_valid), 32'd1);
      check_eq("t1_data", exec_data, 32'hA5A5_0001);
      tick();
      check_eq("t1_one_cycle", 32'(exec_valid), 32'd0);
      tick(); tick();
      exec_done = 1'b1; tick(); exec_done = 1'b0;
      tick();
      check_eq("t1_status", status, 32'h0001_0004);

      // backpressure
      exec_ready = 1'b0;
      push_word(32'h0000_BEEF);
      for (int i = 0; i < 10; i++) begin
         check_eq("bp_valid", 32'(exec_valid), 32'd1);
         check_eq("bp_data", exec_data, 32'h0000_BEEF);
         tick();
      end
      exec_ready = 1'b1;
      tick();
      check_eq("bp_drop", 32'(exec_valid), 32'd0);
      check_eq("bp_data_hold", exec_data, 32'h0000_BEEF);
      exec_ready = 1'b0;
      exec_done = 1'b1; tick(); exec_done = 1'b0;
      tick();
      check_eq("bp_status", status, 32'h0002_0004);

      // overflow: word 1 in ISSUE, 2..5 fill the FIFO, 6th dropped
      for (int w = 1; w <= 5; w++) push_word(32'(w));
      check_eq("ovf_full", status, 32'h0102_0083);
      check_eq("ovf_head", exec_data, 32'd1);
      push_word(32'd6);
      check_eq("ovf_set", status, 32'h0102_008B);
      for (int w = 1; w <= 5; w++) begin
         wait_valid("ovf_wait");
         check_eq("ovf_order", exec_data, 32'(w));
         exec_ready = 1'b1; tick(); exec_ready = 1'b0;
         exec_done = 1'b1; tick(); exec_done = 1'b0;
      end
      tick(); tick();
      check_eq("ovf_drain", status, 32'h0007_000C);
      check_eq("ovf_no6", 32'(exec_valid), 32'd0);

      // timeout after 16 cycles in WAIT_DONE
      exec_ready = 1'b1;
      push_word(32'h77);
      tick();
      exec_ready = 1'b0;
      repeat (15) tick();
      tick();
      check_eq("tmo_not_early", 32'(status[31:24]), 32'd2);
      tick();
      check_eq("tmo_idle", status, 32'h0007_001C);
      exec_done = 1'b1; tick(); exec_done = 1'b0;
      tick(); tick();
      check_eq("tmo_done_ign", status, 32'h0007_001C);

      // flag clear, then clear coinciding with overflow
      clr_flags = 1'b1; tick(); clr_flags = 1'b0;
      tick();
      check_eq("clr_flags", status, 32'h0007_0004);
      for (int w = 16; w <= 20; w++) push_word(32'(w));
      cmd_data = 32'hFF; cmd_wr = 1'b1; clr_flags = 1'b1;
      tick();
      cmd_wr = 1'b0; clr_flags = 1'b0;
      tick();
      check_eq("clr_vs_ovf", status, 32'h0107_008B);

      // async reset during ISSUE
      reset = 1'b1; #2;
      check_eq("rst_issue_valid", 32'(exec_valid), 32'd0);
      check_eq("rst_issue_status", status, 32'h0000_0004);
      tick(); reset = 1'b0; tick();

      // reset mid-WAIT_DONE with two words queued
      push_word(32'h21); push_word(32'h22); push_word(32'h23);
      exec_ready = 1'b1; tick(); exec_ready = 1'b0;
      tick();
      check_eq("rw_queued", status, 32'h0200_0041);
      reset = 1'b1; #2;
      check_eq("rw_status", status, 32'h0000_0004);
      check_eq("rw_valid", 32'(exec_valid), 32'd0);
      check_eq("rw_data", exec_data, 32'd0);
      tick(); reset = 1'b0; tick();
      exec_ready = 1'b1;
      push_word(32'h99);
      check_eq("rw_new_valid", 32'(exec_valid), 32'd1);
      check_eq("rw_new_data", exec_data, 32'h99);
      tick();
      exec_ready = 1'b0;
      exec_done = 1'b1; tick(); exec_done = 1'b0;
      tick(); tick();
      check_eq("rw_final", status, 32'h0001_0004);
      check_eq("rw_no_old", 32'(exec_valid), 32'd0);
      check_eq("rw_retain", exec_data, 32'h99);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
